// File: rtl/cmd_link_arbiter.sv
// Round-robin arbiter sharing one UART command link between NUM_REQ requesters.
// Each transaction sends a 16-bit command as two bytes (high first) and waits for one reply byte.
module cmd_link_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 1048576
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [16*NUM_REQ-1:0]  cmd_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic [NUM_REQ-1:0]     done_o,
  output logic [7:0]             resp_o,
  output logic                   resp_err_o,
  output logic                   trmt_o,
  output logic [7:0]             tx_data_o,
  input  logic                   tx_done_i,
  input  logic                   rx_rdy_i,
  input  logic [7:0]             rx_data_i,
  output logic                   clr_rdy_o
);

  localparam int unsigned PtrW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TimerW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StSendHigh = 2'd1,
    StSendLow  = 2'd2,
    StWaitResp = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [7:0]          resp_q, resp_d;
  logic                resp_err_q, resp_err_d;
  logic                trmt_q, trmt_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                clr_rdy_q, clr_rdy_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [PtrW-1:0]     idx_q, idx_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [15:0]         cmd_q, cmd_d;

  logic                sel_valid;
  logic [PtrW-1:0]     sel_idx;
  logic [PtrW-1:0]     ptr_next;
  logic                rx_valid;

  // rx_rdy is still high in the cycle clr_rdy is out; don't consume that byte twice.
  assign rx_valid = rx_rdy_i & ~clr_rdy_q;

  assign ptr_next = (idx_q == PtrW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      int j;
      j = int'(ptr_q) + i;
      if (j >= int'(NUM_REQ)) begin
        j = j - int'(NUM_REQ);
      end
      if (req_i[j]) begin
        sel_valid = 1'b1;
        sel_idx   = PtrW'(j);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    resp_d     = resp_q;
    resp_err_d = 1'b0;
    trmt_d     = 1'b0;
    tx_data_d  = tx_data_q;
    clr_rdy_d  = 1'b0;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    cmd_d      = cmd_q;

    unique case (state_q)
      StIdle: begin
        gnt_d = '0;
        if (rx_valid) begin
          clr_rdy_d = 1'b1;
        end
        if (sel_valid) begin
          cmd_d     = cmd_i[16*sel_idx +: 16];
          idx_d     = sel_idx;
          gnt_d     = NUM_REQ'(1) << sel_idx;
          trmt_d    = 1'b1;
          tx_data_d = cmd_i[16*sel_idx+8 +: 8];
          state_d   = StSendHigh;
        end
      end

      StSendHigh: begin
        if (rx_valid) begin
          clr_rdy_d = 1'b1;
        end
        if (tx_done_i) begin
          trmt_d    = 1'b1;
          tx_data_d = cmd_q[7:0];
          state_d   = StSendLow;
        end
      end

      StSendLow: begin
        if (rx_valid) begin
          clr_rdy_d = 1'b1;
        end
        if (tx_done_i) begin
          timer_d = '0;
          state_d = StWaitResp;
        end
      end

      StWaitResp: begin
        timer_d = timer_q + 1'b1;
        if (rx_valid) begin
          resp_d    = rx_data_i;
          done_d    = gnt_q;
          clr_rdy_d = 1'b1;
          gnt_d     = '0;
          ptr_d     = ptr_next;
          state_d   = StIdle;
        end else if (timer_q == TimerW'(TIMEOUT_CYC - 1)) begin
          done_d     = gnt_q;
          resp_err_d = 1'b1;
          gnt_d      = '0;
          ptr_d      = ptr_next;
          state_d    = StIdle;
        end
      end

      default: begin
        gnt_d   = '0;
        state_d = StIdle;
      end
    endcase

    // A corrupted grant vector mid-transaction abandons it without a completion.
    if (state_q != StIdle && !$onehot(gnt_q)) begin
      state_d    = StIdle;
      gnt_d      = '0;
      done_d     = '0;
      resp_err_d = 1'b0;
      trmt_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      done_q     <= '0;
      resp_q     <= 8'h00;
      resp_err_q <= 1'b0;
      trmt_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      clr_rdy_q  <= 1'b0;
      ptr_q      <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
      cmd_q      <= 16'h0000;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      resp_q     <= resp_d;
      resp_err_q <= resp_err_d;
      trmt_q     <= trmt_d;
      tx_data_q  <= tx_data_d;
      clr_rdy_q  <= clr_rdy_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      cmd_q      <= cmd_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign done_o     = done_q;
  assign resp_o     = resp_q;
  assign resp_err_o = resp_err_q;
  assign trmt_o     = trmt_q;
  assign tx_data_o  = tx_data_q;
  assign clr_rdy_o  = clr_rdy_q;

endmodule

// File: tb/tb_cmd_link_arbiter.sv
// Directed bench for cmd_link_arbiter: 4 requesters, 16-cycle response timeout.
module tb_cmd_link_arbiter;

  localparam int unsigned NReq = 4;
  localparam int unsigned TOut = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NReq-1:0]   req = '0;
  logic [16*NReq-1:0] cmd;
  logic [NReq-1:0]   gnt, done;
  logic [7:0]        resp, tx_data, rx_data = 8'h00;
  logic              resp_err, trmt, clr_rdy;
  logic              tx_done = 1'b0;
  logic              rx_rdy = 1'b0;

  logic [15:0] cmd_tab [NReq];
  int n_tests = 0;
  int n_fail  = 0;

  cmd_link_arbiter #(
    .NUM_REQ     (NReq),
    .TIMEOUT_CYC (TOut)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .cmd_i      (cmd),
    .gnt_o      (gnt),
    .done_o     (done),
    .resp_o     (resp),
    .resp_err_o (resp_err),
    .trmt_o     (trmt),
    .tx_data_o  (tx_data),
    .tx_done_i  (tx_done),
    .rx_rdy_i   (rx_rdy),
    .rx_data_i  (rx_data),
    .clr_rdy_o  (clr_rdy)
  );

  always #5 clk = ~clk;

  assign cmd = {cmd_tab[3], cmd_tab[2], cmd_tab[1], cmd_tab[0]};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req = '0; tx_done = 1'b0; rx_rdy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Stimulus-only helpers: they return observations, the tests compare.
  task automatic grant_step(output logic [3:0] g, output logic t, output logic [7:0] hi);
    tick();
    g = gnt; t = trmt; hi = tx_data;
  endtask

  task automatic send_bytes(output logic [7:0] lo, output logic t_lo);
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    lo = tx_data; t_lo = trmt;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic respond(input logic [7:0] rsp, output logic [3:0] d, output logic [7:0] r,
                         output logic err, output logic c);
    rx_rdy = 1'b1; rx_data = rsp;
    tick();
    rx_rdy = 1'b0;
    d = done; r = resp; err = resp_err; c = clr_rdy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_tests++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    n_tests++; if (done !== 4'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_tests++; if (resp !== 8'h00) begin n_fail++; $display("FAIL reset_resp: got %h want 00", resp); end
    n_tests++; if ({resp_err, trmt, clr_rdy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 000", {resp_err, trmt, clr_rdy}); end
    n_tests++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_txd: got %h want 00", tx_data); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0] g, d; logic [7:0] hi, lo, r; logic t, tl, err, c;
    cmd_tab[0] = 16'hA55A;
    req = 4'b0001;
    grant_step(g, t, hi);
    n_tests++; if (g !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b want 0001", g); end
    n_tests++; if (t !== 1'b1) begin n_fail++; $display("FAIL single_trmt_hi: got %b want 1", t); end
    n_tests++; if (hi !== 8'hA5) begin n_fail++; $display("FAIL single_hi: got %h want a5", hi); end
    send_bytes(lo, tl);
    n_tests++; if (tl !== 1'b1) begin n_fail++; $display("FAIL single_trmt_lo: got %b want 1", tl); end
    n_tests++; if (lo !== 8'h5A) begin n_fail++; $display("FAIL single_lo: got %h want 5a", lo); end
    respond(8'h3C, d, r, err, c);
    req = 4'b0000;
    n_tests++; if (d !== 4'b0001) begin n_fail++; $display("FAIL single_done: got %b want 0001", d); end
    n_tests++; if (r !== 8'h3C) begin n_fail++; $display("FAIL single_resp: got %h want 3c", r); end
    n_tests++; if ({err, c} !== 2'b01) begin n_fail++; $display("FAIL single_err_clr: got %b want 01", {err, c}); end
    n_tests++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL single_gnt_off: got %b want 0", gnt); end
    tick();
    n_tests++; if ({done, clr_rdy} !== 5'b0) begin
      n_fail++; $display("FAIL single_pulse_len: got %b want 00000", {done, clr_rdy}); end
  endtask

  task automatic test_fairness();
    logic [3:0] g, d, eg; logic [7:0] hi, lo, r; logic t, tl, err, c;
    apply_reset();
    cmd_tab[0] = 16'h0102; cmd_tab[1] = 16'h1112; cmd_tab[2] = 16'h2122; cmd_tab[3] = 16'h3132;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      eg = 4'b0001 << (k % 4);
      grant_step(g, t, hi);
      n_tests++; if (g !== eg) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, g, eg); end
      n_tests++; if (hi !== cmd_tab[k % 4][15:8]) begin
        n_fail++; $display("FAIL rr_hi[%0d]: got %h want %h", k, hi, cmd_tab[k % 4][15:8]); end
      send_bytes(lo, tl);
      n_tests++; if (lo !== cmd_tab[k % 4][7:0]) begin
        n_fail++; $display("FAIL rr_lo[%0d]: got %h want %h", k, lo, cmd_tab[k % 4][7:0]); end
      respond(8'h40 + 8'(k), d, r, err, c);
      n_tests++; if (d !== eg) begin n_fail++; $display("FAIL rr_done[%0d]: got %b want %b", k, d, eg); end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_pointer();
    logic [3:0] g, d; logic [7:0] hi, lo, r; logic t, tl, err, c;
    req = 4'b0100;
    grant_step(g, t, hi);
    n_tests++; if (g !== 4'b0100) begin n_fail++; $display("FAIL ptr_gnt2: got %b want 0100", g); end
    req = 4'b1010;  // requester 2 drops its req mid-transaction
    send_bytes(lo, tl);
    respond(8'h55, d, r, err, c);
    n_tests++; if (d !== 4'b0100) begin n_fail++; $display("FAIL ptr_done2: got %b want 0100", d); end
    grant_step(g, t, hi);
    n_tests++; if (g !== 4'b1000) begin n_fail++; $display("FAIL ptr_gnt3: got %b want 1000", g); end
    send_bytes(lo, tl);
    respond(8'h66, d, r, err, c);
    grant_step(g, t, hi);
    n_tests++; if (g !== 4'b0010) begin n_fail++; $display("FAIL ptr_gnt1: got %b want 0010", g); end
    send_bytes(lo, tl);
    respond(8'h77, d, r, err, c);
    req = 4'b0000;
    tick();
  endtask

  task automatic test_timeout();
    logic [3:0] g, d; logic [7:0] hi, lo, r; logic t, tl, err, c;
    req = 4'b0010;
    grant_step(g, t, hi);
    req = 4'b0000;
    send_bytes(lo, tl);
    for (int k = 0; k < int'(TOut) - 1; k++) tick();
    n_tests++; if (done !== 4'b0) begin n_fail++; $display("FAIL to_early: got %b want 0", done); end
    tick();
    n_tests++; if (done !== 4'b0010) begin n_fail++; $display("FAIL to_done: got %b want 0010", done); end
    n_tests++; if (resp_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", resp_err); end
    n_tests++; if (resp !== 8'h77) begin n_fail++; $display("FAIL to_resp_kept: got %h want 77", resp); end
    n_tests++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL to_gnt_off: got %b want 0", gnt); end
    // Pointer should now be 2, so requester 2 beats requester 1.
    req = 4'b0110;
    grant_step(g, t, hi);
    n_tests++; if (g !== 4'b0100) begin n_fail++; $display("FAIL to_ptr: got %b want 0100", g); end
    req = 4'b0000;
    send_bytes(lo, tl);
    for (int k = 0; k < int'(TOut) - 1; k++) tick();
    respond(8'h99, d, r, err, c);
    n_tests++; if (d !== 4'b0100) begin n_fail++; $display("FAIL race_done: got %b want 0100", d); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL race_err: got %b want 0", err); end
    n_tests++; if (r !== 8'h99) begin n_fail++; $display("FAIL race_resp: got %h want 99", r); end
    tick();
  endtask

  task automatic test_stale();
    rx_rdy = 1'b1; rx_data = 8'hEE;
    tick();
    rx_rdy = 1'b0;
    n_tests++; if (clr_rdy !== 1'b1) begin n_fail++; $display("FAIL stale_clr: got %b want 1", clr_rdy); end
    n_tests++; if (done !== 4'b0) begin n_fail++; $display("FAIL stale_done: got %b want 0", done); end
    n_tests++; if (resp !== 8'h99) begin n_fail++; $display("FAIL stale_resp: got %h want 99", resp); end
    tick();
    n_tests++; if (clr_rdy !== 1'b0) begin n_fail++; $display("FAIL stale_clr_len: got %b want 0", clr_rdy); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] g, d; logic [7:0] hi, lo, r; logic t, tl, err, c;
    req = 4'b0001;
    grant_step(g, t, hi);
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    n_tests++; if (trmt !== 1'b1) begin n_fail++; $display("FAIL rm_in_low: got %b want 1", trmt); end
    rst = 1'b1;
    #1;
    n_tests++; if ({gnt, done, trmt} !== 9'b0) begin
      n_fail++; $display("FAIL rm_async: got %b want 0", {gnt, done, trmt}); end
    n_tests++; if (resp !== 8'h00) begin n_fail++; $display("FAIL rm_resp: got %h want 00", resp); end
    tick();
    rst = 1'b0;
    req = 4'b1000;
    grant_step(g, t, hi);
    n_tests++; if (g !== 4'b1000) begin n_fail++; $display("FAIL rm_gnt3: got %b want 1000", g); end
    n_tests++; if ({t, hi} !== {1'b1, cmd_tab[3][15:8]}) begin
      n_fail++; $display("FAIL rm_tx: got %b/%h want 1/%h", t, hi, cmd_tab[3][15:8]); end
    req = 4'b0000;
    send_bytes(lo, tl);
    respond(8'h12, d, r, err, c);
    n_tests++; if (d !== 4'b1000) begin n_fail++; $display("FAIL rm_done3: got %b want 1000", d); end
  endtask

  initial begin
    for (int i = 0; i < int'(NReq); i++) cmd_tab[i] = 16'h0000;
    apply_reset();
    test_reset();
    test_single();
    test_fairness();
    test_pointer();
    test_timeout();
    test_stale();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_link_arbiter.md
Name: cmd_link_arbiter

Overview:
- Shares one UART command link between NUM_REQ requesters. Each requester issues a 16-bit command, which goes out as two bytes, high byte first, and waits for a single response byte.
- Round-robin arbitration; one transaction outstanding at a time.
- Sits between the command sources (test/config engines) and the UART transceiver. It sequences trmt/tx_data, consumes rdy/rx byte, and drives clr_rdy.
- A response timeout prevents a dead link from locking the arbiter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 1048576, clk cycles to wait in WAIT_RESP before declaring a timeout (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held high until its done pulse.
- cmd_in  in  16*NUM_REQ  requester i's command on bits [16*i+15:16*i]; stable while req[i] is high.
- gnt  out  NUM_REQ  one-hot grant, high for the whole transaction.
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- resp  out  8  last response byte; held until overwritten.
- resp_err  out  1  high only in the done cycle, when that completion was a timeout.
- trmt  out  1  one-cycle UART transmit strobe.
- tx_data  out  8  byte to transmit; stable from the trmt cycle until tx_done.
- tx_done  in  1  UART byte-sent pulse.
- rx_rdy  in  1  UART received-byte ready (level; cleared by clr_rdy).
- rx_data  in  8  UART received byte.
- clr_rdy  out  1  one-cycle pulse that clears rx_rdy.

Behaviour:
- Reset values:
  - state=IDLE, gnt=0, done=0, resp=8'h00, resp_err=0.
  - trmt=0, tx_data=8'h00, clr_rdy=0.
  - round-robin pointer ptr=0, timer=0.
  - Reset asserted mid-transaction aborts immediately to these values. A UART byte already in flight is not cancelled.
- All outputs are registered.
- IDLE:
  - If req!=0, select the first set req[i] scanning ptr, ptr+1, ... mod NUM_REQ.
  - On the next edge: latch cmd_in[i] into cmd_reg, set gnt[i], trmt=1, tx_data=cmd_reg[15:8], go to SEND_HIGH.
  - Latency is 1 cycle from req to gnt/trmt.
- SEND_HIGH:
  - trmt is high only in the first cycle.
  - On tx_done: next cycle trmt=1, tx_data=cmd_reg[7:0], go to SEND_LOW.
- SEND_LOW:
  - On tx_done: go to WAIT_RESP with timer=0.
- WAIT_RESP:
  - timer increments each cycle.
  - If rx_rdy=1: next cycle resp=rx_data, done[i]=1, clr_rdy=1, resp_err=0, gnt=0, ptr=(i+1) mod NUM_REQ, go to IDLE.
  - Else if timer==TIMEOUT_CYC-1: next cycle done[i]=1, resp_err=1, resp unchanged, gnt=0, ptr advanced as above, go to IDLE.
  - When rx_rdy and the timeout coincide, rx_rdy wins (normal completion).
  - The timeout completion occurs exactly TIMEOUT_CYC cycles after entering WAIT_RESP.
- req is sampled only in IDLE:
  - Deassertion of a granted req mid-transaction is ignored; the transaction completes and done still pulses.
  - Changes on non-granted reqs do not disturb the current transaction.
- Stale rx_rdy:
  - rx_rdy seen in IDLE, SEND_HIGH or SEND_LOW is discarded: clr_rdy pulses the next cycle, resp unchanged, no done.
  - In IDLE, arbitration proceeds in the same cycle.
- tx_done seen in IDLE or WAIT_RESP is ignored.
- Every completion returns to IDLE for at least one cycle. A new grant is earliest 1 cycle after done.
- If multiple gnt bits are set or state is an illegal encoding, the FSM recovers to IDLE.

Test Plan:
1. Single request: after reset, req[0]=1 with cmd 16'hA55A.
   - Required: trmt, tx_data=8'hA5; on tx_done, trmt, tx_data=8'h5A; on tx_done, enter WAIT_RESP.
   - Then rx_rdy with rx_data=8'h3C gives done[0] for 1 cycle, resp=8'h3C, clr_rdy for 1 cycle, resp_err=0, gnt=0.
2. Fairness: req=4'b1111 held continuously, every response answered.
   - Required: grants in order 0,1,2,3,0. Exactly one gnt bit at a time. done matches gnt each transaction.
3. Pointer advance: during requester 2's transaction, assert req[1] and req[3].
   - Required: next grant goes to 3, then to 1.
4. Timeout: TIMEOUT_CYC=16, req[1]=1, never assert rx_rdy.
   - Required: done[1] and resp_err=1 exactly 16 cycles after entering WAIT_RESP; resp keeps its prior value; ptr=2.
   - Repeat with rx_rdy arriving on the 16th cycle: normal completion, resp_err=0.
5. Stale byte: pulse rx_rdy in IDLE with req=0.
   - Required: clr_rdy pulses next cycle, no done, resp unchanged.
6. Reset mid-transaction: assert rst during SEND_LOW.
   - Required: gnt=0, trmt=0, done=0, resp=0, ptr=0 immediately.
   - After release, req[3] is granted 1 cycle after it is sampled.
